pulse_rate_counter: RTL and testbench

//  Parametrised synchronous successor to the 8-bit ripple counter of the rotational-speed meter.

---
 rtl/speed_meter_pkg.sv | 23 ++
 rtl/pulse_sync_edge.sv | 26 ++
 rtl/pulse_rate_counter.sv | 112 +++++++++++
 tb/tb_pulse_rate_counter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/speed_meter_pkg.sv
// Shared types and helpers for the rotational-speed meter pulse counter.
package speed_meter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    function automatic int unsigned gate_w(input int unsigned cycles);
        return $clog2(cycles);
    endfunction

    // Holds at 2^width-1 instead of wrapping; width must stay below 32.
    function automatic logic [31:0] sat_inc(input logic [31:0] acc, input logic inc,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (32'd1 << width) - 32'd1;
        if (inc && (acc < max_val))
            return acc + 32'd1;
        return acc;
    endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Multi-flop synchroniser for the asynchronous sensor pulse plus rising-edge detector.
module pulse_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/pulse_rate_counter.sv
// Counts synchronised sensor edges inside a GATE_CYCLES window and latches a saturating result.
module pulse_rate_counter
    import speed_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CONTINUOUS  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] count_out,
    output logic             count_valid,
    output logic             overflow
);

    localparam int unsigned        GATE_W     = gate_w(GATE_CYCLES);
    localparam logic [GATE_W-1:0]  TIMER_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [WIDTH-1:0]   ACC_MAX    = '1;
    localparam logic               AUTO       = (CONTINUOUS != 0);

    state_t             state_q, state_d;
    logic [GATE_W-1:0]  timer_q, timer_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               rise;
    logic [WIDTH-1:0]   acc_inc;
    logic               sat_now;

    pulse_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        acc_inc = WIDTH'(sat_inc(32'(acc_q), rise, WIDTH));
        sat_now = sat_q | (rise & (acc_q == ACC_MAX));
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (AUTO || start) begin
                    state_d = GATE;
                    timer_d = TIMER_LOAD;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    // The terminal-cycle edge belongs to the window that is closing.
                    count_d = acc_inc;
                    ovf_d   = sat_now;
                    valid_d = 1'b1;
                    if (AUTO || start) begin
                        timer_d = TIMER_LOAD;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                    acc_d   = acc_inc;
                    sat_d   = sat_now;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == GATE);
    assign count_out   = count_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Scoreboard bench for pulse_rate_counter in single-shot, narrow-width and continuous configurations.
module tb_pulse_rate_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic start_a, start_b, pulse_in;

    logic       busy_a, cv_a, ov_a;
    logic [7:0] cnt_a;
    logic       busy_b, cv_b, ov_b;
    logic [3:0] cnt_b;
    logic       busy_c, cv_c, ov_c;
    logic [7:0] cnt_c;

    pulse_rate_counter #(.WIDTH(8), .GATE_CYCLES(100), .CONTINUOUS(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst_a), .pulse_in(pulse_in), .start(start_a),
        .busy(busy_a), .count_out(cnt_a), .count_valid(cv_a), .overflow(ov_a));

    pulse_rate_counter #(.WIDTH(4), .GATE_CYCLES(100), .CONTINUOUS(0), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst_b), .pulse_in(pulse_in), .start(start_b),
        .busy(busy_b), .count_out(cnt_b), .count_valid(cv_b), .overflow(ov_b));

    pulse_rate_counter #(.WIDTH(8), .GATE_CYCLES(50), .CONTINUOUS(1), .SYNC_STAGES(2)) dut_c (
        .clk(clk), .rst(rst_c), .pulse_in(pulse_in), .start(1'b0),
        .busy(busy_c), .count_out(cnt_c), .count_valid(cv_c), .overflow(ov_c));

    typedef struct {
        int cnt;
        int ovf;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t sb_c[$];
    exp_t ea, eb, ec;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int busy_cnt_a = 0;
    int sum_c = 0;
    int nres_c = 0;
    int last_c = -1;
    logic pv_a = 1'b0;
    logic pv_b = 1'b0;
    logic pv_c = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: count_valid=1 with no result pending, required 0", name);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (cv_a) begin
            if (sb_a.size() == 0) unexpected("a_valid");
            else begin
                ea = sb_a.pop_front();
                check("a_count", 32'(cnt_a), ea.cnt);
                check("a_overflow", 32'(ov_a), ea.ovf);
            end
            check("a_valid_back_to_back", 32'(pv_a), 0);
        end
        pv_a = cv_a;
        if (busy_a) busy_cnt_a++;
    end

    always @(negedge clk) begin
        if (cv_b) begin
            if (sb_b.size() == 0) unexpected("b_valid");
            else begin
                eb = sb_b.pop_front();
                check("b_count", 32'(cnt_b), eb.cnt);
                check("b_overflow", 32'(ov_b), eb.ovf);
            end
            check("b_valid_back_to_back", 32'(pv_b), 0);
        end
        pv_b = cv_b;
    end

    always @(negedge clk) begin
        if (cv_c) begin
            if (sb_c.size() == 0) unexpected("c_valid");
            else begin
                ec = sb_c.pop_front();
                check("c_count", 32'(cnt_c), ec.cnt);
                check("c_overflow", 32'(ov_c), ec.ovf);
            end
            check("c_valid_back_to_back", 32'(pv_c), 0);
            if (last_c >= 0) check("c_valid_spacing", 32'(cyc - last_c), 50);
            last_c = cyc;
            sum_c += int'(cnt_c);
            nres_c++;
        end
        pv_c = cv_c;
    end

    // Called just after a clock edge; the next edge samples start.
    task automatic launch(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Cycle j is the interval after the j-th edge following the start-sampling edge;
    // a rise driven in cycle j reaches the accumulator on edge j+3.
    task automatic drive(input int ncyc, input int first, input int period, input int npulse,
                         input int extra, input int mid_at);
        int rel;
        logic train, ex;
        for (int j = 1; j <= ncyc; j++) begin
            @(posedge clk);
            #1;
            rel = j - first;
            train = (npulse > 0) && (rel >= 0) && (rel < period * npulse) && ((rel % period) < (period / 2));
            ex = (extra > 0) && (j >= extra) && (j <= extra + 2);
            pulse_in = train | ex;
            start_a = (j == mid_at);
        end
        pulse_in = 1'b0;
        start_a = 1'b0;
    endtask

    task automatic run_a(input int first, input int period, input int npulse,
                         input int extra, input int mid_at);
        int base;
        base = busy_cnt_a;
        launch(0);
        drive(110, first, period, npulse, extra, mid_at);
        check("a_busy_cycles", 32'(busy_cnt_a - base), 100);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; pulse_in = 1'b0;

        // Reset held with the sensor toggling
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 pulse_in = ~pulse_in;
        end
        @(negedge clk);
        check("rst_a_count", 32'(cnt_a), 0);
        check("rst_a_valid", 32'(cv_a), 0);
        check("rst_a_overflow", 32'(ov_a), 0);
        check("rst_a_busy", 32'(busy_a), 0);
        check("rst_b_count", 32'(cnt_b), 0);
        check("rst_c_busy", 32'(busy_c), 0);
        @(posedge clk);
        #1 pulse_in = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Period-10 train, ten rises inside one window
        sb_a.push_back('{10, 0});
        run_a(5, 10, 10, 0, -1);

        // Rise landing on the terminal cycle counts; start mid-window is ignored
        sb_a.push_back('{2, 0});
        run_a(10, 6, 1, 97, 50);
        // One cycle later the rise falls after the window closes
        sb_a.push_back('{1, 0});
        run_a(20, 6, 1, 98, -1);

        // Reset mid-window after 30 edges
        launch(0);
        drive(92, 1, 3, 30, 0, -1);
        check("a_busy_before_abort", 32'(busy_a), 1);
        rst_a = 1'b0;
        #1;
        check("abort_count", 32'(cnt_a), 0);
        check("abort_valid", 32'(cv_a), 0);
        check("abort_overflow", 32'(ov_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sb_a.push_back('{10, 0});
        run_a(5, 10, 10, 0, -1);

        // 4-bit result: 25 edges saturate, then a clean window of 10
        sb_b.push_back('{15, 1});
        launch(1);
        drive(110, 1, 4, 25, 0, -1);
        sb_b.push_back('{10, 0});
        launch(1);
        drive(110, 5, 10, 10, 0, -1);

        // Continuous gating: ten back-to-back windows of ten edges each
        for (int w = 0; w < 10; w++) sb_c.push_back('{10, 0});
        rst_c = 1'b1;
        @(posedge clk);
        #1;
        drive(510, 1, 5, 100, 0, -1);
        rst_c = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("a_results_outstanding", 32'(sb_a.size()), 0);
        check("b_results_outstanding", 32'(sb_b.size()), 0);
        check("c_results_outstanding", 32'(sb_c.size()), 0);
        check("c_result_count", 32'(nres_c), 10);
        check("c_sum_of_edges", 32'(sum_c), 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
